// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format codes,
// opcode constants, pipeline state and the opcode auto-decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_CSRI  = 3'b110,
    IMM_NONE  = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } pipe_state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  // src: format to extract; bad: opcode not supported;
  // w5: word-shift, shamt limited to 5 bits even on RV64
  typedef struct packed {
    imm_src_e src;
    logic     bad;
    logic     w5;
  } fmt_sel_t;

  function automatic fmt_sel_t auto_fmt(
    input logic [31:0] instr,
    input logic        rv64
  );
    fmt_sel_t s;
    logic     sh;
    sh = (instr[14:12] == 3'b001) ||
         (instr[14:12] == 3'b101);
    s.src = IMM_NONE;
    s.bad = 1'b0;
    s.w5  = 1'b0;
    case (instr[6:0])
      OP_IMM:
        s.src = sh ? IMM_SHAMT : IMM_I;
      OP_LOAD, OP_JALR, OP_FENCE:
        s.src = IMM_I;
      OP_STORE:
        s.src = IMM_S;
      OP_BRANCH:
        s.src = IMM_B;
      OP_JAL:
        s.src = IMM_J;
      OP_LUI, OP_AUIPC:
        s.src = IMM_U;
      OP_REG, OP_REG32:
        s.src = IMM_NONE;
      OP_SYSTEM:
        s.src = instr[14] ? IMM_CSRI : IMM_NONE;
      OP_IMM32: begin
        s.src = sh ? IMM_SHAMT : IMM_I;
        s.w5  = 1'b1;
        s.bad = !rv64;
      end
      default:
        s.bad = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: instr + format -> imm, illegal.
// IMM_GEN_ZICSR_EN enables the CSR zimm format; otherwise it is illegal.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_e        src,
  input  logic            w5,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // opcode bits are consumed by the format selector, not here
  logic unused_op;
  assign unused_op = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (src)
      IMM_I:
        imm = XLEN'($signed(instr[31:20]));
      IMM_S:
        imm = XLEN'($signed({instr[31:25],
                             instr[11:7]}));
      IMM_B:
        imm = XLEN'($signed({instr[31], instr[7],
                             instr[30:25],
                             instr[11:8], 1'b0}));
      IMM_J:
        imm = XLEN'($signed({instr[31],
                             instr[19:12],
                             instr[20],
                             instr[30:21], 1'b0}));
      IMM_U:
        imm = XLEN'($signed({instr[31:12],
                             12'b0}));
      IMM_SHAMT: begin
        if (XLEN == 64 && !w5) begin
          imm = XLEN'(instr[25:20]);
        end else begin
          // bit 25 set selects a shift beyond 31
          imm     = XLEN'(instr[24:20]);
          illegal = instr[25];
        end
      end
      IMM_CSRI: begin
`ifdef IMM_GEN_ZICSR_EN
        imm = XLEN'(instr[19:15]);
`else
        illegal = 1'b1;
`endif
      end
      default:
        imm = '0;
    endcase
    if (illegal) imm = '0;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready and 2-entry skid.
// Ports: clk, rst_n, flush, in_* handshake + instr/imm_src/in_tag,
// out_* handshake + imm_ext/out_illegal/out_tag.
// Macro IMM_GEN_ZICSR_EN enables the CSRI (zimm) format.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  imm_src_e         imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  fmt_sel_t        sel_auto;
  fmt_sel_t        sel;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic [XLEN-1:0] in_imm;
  logic            in_ill;

  assign sel_auto = auto_fmt(instr, XLEN == 64);

  always_comb begin
    sel = sel_auto;
    if (!AUTO_DECODE) begin
      sel.src = imm_src;
      sel.bad = 1'b0;
      sel.w5  = 1'b0;
    end
  end

  imm_decode #(
    .XLEN(XLEN)
  ) u_dec (
    .instr  (instr),
    .src    (sel.src),
    .w5     (sel.w5),
    .imm    (dec_imm),
    .illegal(dec_ill)
  );

  assign in_ill = sel.bad | dec_ill;
  assign in_imm = in_ill ? '0 : dec_imm;

  pipe_state_e     state_q;
  pipe_state_e     state_d;
  logic            ld_main;
  logic            from_skid;
  logic            ld_skid;
  logic            acc;
  logic            drn;

  logic [XLEN-1:0]  main_imm;
  logic             main_ill;
  logic [TAG_W-1:0] main_tag;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  // handshake flags depend only on the registered state
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    ld_main   = 1'b0;
    from_skid = 1'b0;
    ld_skid   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            ld_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && drn) begin
            ld_main = 1'b1;
          end else if (acc) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            state_d   = ONE;
            ld_main   = 1'b1;
            from_skid = 1'b1;
          end
        end
        default:
          state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm <= '0;
      main_ill <= 1'b0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
      skid_tag <= '0;
    end else begin
      if (ld_main) begin
        main_imm <= from_skid ? skid_imm : in_imm;
        main_ill <= from_skid ? skid_ill : in_ill;
        main_tag <= from_skid ? skid_tag : in_tag;
      end
      if (ld_skid) begin
        skid_imm <= in_imm;
        skid_ill <= in_ill;
        skid_tag <= in_tag;
      end
    end
  end

  assign imm_ext     = main_imm;
  assign out_illegal = main_ill;
  assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 explicit-format and RV64 auto-decode
// instances share one stimulus stream, checked against a queue model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

`ifdef IMM_GEN_ZICSR_EN
  localparam bit ZICSR = 1'b1;
`else
  localparam bit ZICSR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] in_tag = '0;
  imm_src_e    imm_src = IMM_I;

  logic        rdy32, ov32, il32;
  logic [31:0] imm32, tag32;
  logic        rdy64, ov64, il64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(32)
  ) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
    .imm_ext(imm32), .out_illegal(il32), .out_tag(tag32)
  );

  imm_gen_pipe #(
    .XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(32)
  ) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
    .imm_ext(imm64), .out_illegal(il64), .out_tag(tag64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: immediate value straight from the ISA field layout
  function automatic exp_t model(input logic [31:0] i,
                                 input imm_src_e s,
                                 input bit x64,
                                 input bit auto_d,
                                 input logic [31:0] tag);
    exp_t   e;
    int     fmt;
    bit     ill;
    bit     w5;
    longint v;
    fmt = int'(s);
    ill = 0;
    w5  = 0;
    v   = 0;
    if (auto_d) begin
      case (i[6:0])
        7'h13: fmt = (i[14:12] == 3'b001 ||
                      i[14:12] == 3'b101) ? 5 : 0;
        7'h03, 7'h67, 7'h0F: fmt = 0;
        7'h23: fmt = 1;
        7'h63: fmt = 2;
        7'h6F: fmt = 3;
        7'h37, 7'h17: fmt = 4;
        7'h33, 7'h3B: fmt = 7;
        7'h73: fmt = i[14] ? 6 : 7;
        7'h1B: begin
          fmt = (i[14:12] == 3'b001 ||
                 i[14:12] == 3'b101) ? 5 : 0;
          w5  = 1;
          if (!x64) ill = 1;
        end
        default: ill = 1;
      endcase
    end
    case (fmt)
      0: v = longint'($signed(i[31:20]));
      1: v = longint'($signed({i[31:25], i[11:7]}));
      2: v = longint'($signed({i[31], i[7], i[30:25],
                               i[11:8], 1'b0}));
      3: v = longint'($signed({i[31], i[19:12], i[20],
                               i[30:21], 1'b0}));
      4: v = longint'($signed({i[31:12], 12'b0}));
      5: begin
        if (x64 && !w5) v = longint'(i[25:20]);
        else begin
          v = longint'(i[24:20]);
          if (i[25]) ill = 1;
        end
      end
      6: begin
        if (ZICSR) v = longint'(i[19:15]);
        else ill = 1;
      end
      default: v = 0;
    endcase
    if (ill) v = 0;
    e.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    e.ill = ill;
    e.tag = tag;
    return e;
  endfunction

  // per-cycle compare and scoreboard update
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      q64.delete();
    end else begin
      chk("m32.valid", 64'(ov32), 64'(q32.size() != 0));
      chk("m32.ready", 64'(rdy32), 64'(q32.size() < 2));
      chk("m64.valid", 64'(ov64), 64'(q64.size() != 0));
      chk("m64.ready", 64'(rdy64), 64'(q64.size() < 2));
      if (ov32 && q32.size() != 0) begin
        chk("m32.imm", {32'b0, imm32}, q32[0].imm);
        chk("m32.ill", 64'(il32), 64'(q32[0].ill));
        chk("m32.tag", 64'(tag32), 64'(q32[0].tag));
        if (out_ready && !flush) void'(q32.pop_front());
      end
      if (ov64 && q64.size() != 0) begin
        chk("m64.imm", imm64, q64[0].imm);
        chk("m64.ill", 64'(il64), 64'(q64[0].ill));
        chk("m64.tag", 64'(tag64), 64'(q64[0].tag));
        if (out_ready && !flush) void'(q64.pop_front());
      end
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (in_valid) begin
        if (rdy32)
          q32.push_back(model(instr, imm_src, 0, 0, in_tag));
        if (rdy64)
          q64.push_back(model(instr, imm_src, 1, 1, in_tag));
      end
    end
  end

  // hold in_valid until accepted; returns just after the accept edge
  task automatic wait_acc(input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy32) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL %s.timeout: got no accept expected accept", nm);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input imm_src_e s);
    instr    = ins;
    imm_src  = s;
    in_tag   = in_tag + 32'h11;
    in_valid = 1'b1;
    wait_acc("push");
  endtask

  // single beat with literal expectations for both instances
  task automatic pin(input string nm,
                     input logic [31:0] ins, input imm_src_e s,
                     input logic [31:0] e32, input logic i32,
                     input logic [63:0] e64, input logic i64);
    logic [31:0] t;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(ins, s);
    t = in_tag;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".v32"}, 64'(ov32), 64'd1);
    chk({nm, ".imm32"}, 64'(imm32), 64'(e32));
    chk({nm, ".ill32"}, 64'(il32), 64'(i32));
    chk({nm, ".tag32"}, 64'(tag32), 64'(t));
    chk({nm, ".v64"}, 64'(ov64), 64'd1);
    chk({nm, ".imm64"}, imm64, e64);
    chk({nm, ".ill64"}, 64'(il64), 64'(i64));
  endtask

  typedef struct packed {
    logic [31:0] ins;
    imm_src_e    s;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] t0;
    vecs[0] = '{32'hFFF00093, IMM_I};
    vecs[1] = '{32'hFE000EE3, IMM_B};
    vecs[2] = '{32'h0020A423, IMM_S};
    vecs[3] = '{32'h800002B7, IMM_U};
    vecs[4] = '{32'h02009093, IMM_SHAMT};
    vecs[5] = '{32'hFFDFF0EF, IMM_J};
    vecs[6] = '{32'h0002D073, IMM_CSRI};
    vecs[7] = '{32'h0000007F, IMM_NONE};

    #1 rst_n = 1'b0;
    #1;
    chk("rst.v32", 64'(ov32), 64'd0);
    chk("rst.rdy32", 64'(rdy32), 64'd1);
    chk("rst.imm32", 64'(imm32), 64'd0);
    chk("rst.ill32", 64'(il32), 64'd0);
    chk("rst.tag32", 64'(tag32), 64'd0);
    chk("rst.imm64", imm64, 64'd0);
    #10 rst_n = 1'b1;

    pin("i_neg", 32'hFFF00093, IMM_I, 32'hFFFFFFFF, 0,
        64'hFFFFFFFFFFFFFFFF, 0);
    pin("b_neg", 32'hFE000EE3, IMM_B, 32'hFFFFFFFC, 0,
        64'hFFFFFFFFFFFFFFFC, 0);
    pin("s_pos", 32'h0020A423, IMM_S, 32'h00000008, 0,
        64'h8, 0);
    pin("lui", 32'h800002B7, IMM_U, 32'h80000000, 0,
        64'hFFFFFFFF80000000, 0);
    pin("slli32", 32'h02009093, IMM_SHAMT, 32'h0, 1,
        64'h20, 0);
    pin("csri", 32'h0002D073, IMM_CSRI,
        ZICSR ? 32'h5 : 32'h0, !ZICSR,
        ZICSR ? 64'h5 : 64'h0, !ZICSR);
    pin("jal", 32'hFFDFF0EF, IMM_J, 32'hFFFFFFFC, 0,
        64'hFFFFFFFFFFFFFFFC, 0);
    pin("add", 32'h00B50533, IMM_NONE, 32'h0, 0, 64'h0, 0);
    pin("badop", 32'h0000007F, IMM_I, 32'h0, 0, 64'h0, 1);
    pin("addiw", 32'hFFF5051B, IMM_I, 32'hFFFFFFFF, 0,
        64'hFFFFFFFFFFFFFFFF, 0);
    pin("slliw", 32'h0015151B, IMM_SHAMT, 32'h1, 0, 64'h1, 0);
    pin("srai", 32'h4010D093, IMM_SHAMT, 32'h1, 0, 64'h1, 0);
    pin("lw", 32'h80002083, IMM_I, 32'hFFFFF800, 0,
        64'hFFFFFFFFFFFFF800, 0);
    pin("auipc", 32'h12345017, IMM_U, 32'h12345000, 0,
        64'h12345000, 0);

    // backpressure: two accepts fill the buffer
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(32'hFFF00093, IMM_I);
    t0 = in_tag;
    push(32'h0020A423, IMM_S);
    instr    = 32'h800002B7;
    imm_src  = IMM_U;
    in_tag   = in_tag + 32'h11;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp.rdy", 64'(rdy32), 64'd0);
      chk("bp.tag", 64'(tag32), 64'(t0));
      chk("bp.imm", 64'(imm32), 64'hFFFFFFFF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_acc("bp");
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp.drain32", 64'(q32.size()), 64'd0);
    chk("bp.drain64", 64'(q64.size()), 64'd0);

    // flush while full, with a new input offered
    out_ready = 1'b0;
    push(32'hFFDFF0EF, IMM_J);
    push(32'hFE000EE3, IMM_B);
    instr    = 32'h12345017;
    imm_src  = IMM_U;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl.v32", 64'(ov32), 64'd0);
    chk("fl.v64", 64'(ov64), 64'd0);
    chk("fl.rdy32", 64'(rdy32), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("fl.none", 64'(ov32 | ov64), 64'd0);
    end

    // mixed stream with a fixed stall pattern
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 3) != 2;
      push(vecs[i % 8].ins, vecs[i % 8].s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("st.drain32", 64'(q32.size()), 64'd0);
    chk("st.drain64", 64'(q64.size()), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    push(32'hFFF00093, IMM_I);
    push(32'hFE000EE3, IMM_B);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.v32", 64'(ov32), 64'd0);
    chk("ar.imm32", 64'(imm32), 64'd0);
    chk("ar.tag32", 64'(tag32), 64'd0);
    chk("ar.rdy32", 64'(rdy32), 64'd1);
    chk("ar.imm64", imm64, 64'd0);
    chk("ar.v64", 64'(ov64), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    pin("post_rst", 32'h0020A423, IMM_S, 32'h8, 0, 64'h8, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the RISC-V decode stage. Extracts and sign/zero-extends the immediate from a 32-bit instruction for RV32 or RV64. The format comes from an explicit imm_src code or is auto-decoded from the opcode. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, and unsupported formats raise an illegal flag instead of halting simulation.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
AUTO_DECODE, 0, 1 = derive the format from instr[6:0]/funct3 and ignore imm_src; 0 = use imm_src.
TAG_W, 32, width of the sideband tag (PC or ROB id) carried alongside each instruction.

Ports:
clk  input  1  clock, all state on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous drop of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept an instruction this cycle
instr  input  32  raw instruction word
imm_src  input  3  format code (imm_pkg::imm_src_e); ignored when AUTO_DECODE=1
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts the output entry
imm_ext  output  XLEN  extended immediate
out_illegal  output  1  format unsupported or reserved encoding
out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Reset: out_valid=0, in_ready=1, imm_ext=0, out_illegal=0, out_tag=0, state EMPTY. Reset is asynchronous: asserting rst_n mid-transfer drops all entries.
- Format codes:
  - I=000: instr[31:20], sign-extended.
  - S=001: {instr[31:25], instr[11:7]}, sign-extended.
  - B=010: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - J=011: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - U=100: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - SHAMT=101: zero-extended shift amount. XLEN=32 uses instr[24:20], and instr[25]=1 is illegal. XLEN=64 uses instr[25:20].
  - CSRI=110: see Optional Feature.
  - NONE=111: imm_ext=0, legal.
- Illegal entries: imm_ext=0, out_illegal=1. The entry still flows through the pipeline like a legal one.
- AUTO_DECODE opcode mapping:
  - 0010011: I, or SHAMT when funct3 is 001 or 101.
  - 0000011, 1100111, 0001111: I.
  - 0100011: S.
  - 1100011: B.
  - 1101111: J.
  - 0110111, 0010111: U.
  - 0110011, 0111011: NONE.
  - 1110011: CSRI when funct3[2]=1, otherwise NONE.
  - 0011011 (RV64 only): I, or SHAMT (5-bit) when funct3 is 001 or 101.
  - Any other opcode: illegal.
- Latency: 1 cycle from an in_valid&in_ready edge to out_valid. Throughput is 1 per cycle when out_ready stays high.
- Output buffering: main register feeds the outputs; a skid register holds one extra entry. States:
  - EMPTY: in_ready=1, out_valid=0. An accept moves to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept with drain: stay ONE, main register reloads.
    - Accept without drain: go FULL, new entry into skid.
    - Drain without accept: go EMPTY.
  - FULL: in_ready=0, out_valid=1. On drain, skid moves to main and the state goes to ONE.
- Outputs hold stable while out_valid=1 and out_ready=0.
- in_ready is a registered function of state only; no combinational path from out_ready.
- flush: next state EMPTY and out_valid=0. An input presented in the same cycle is discarded. flush has priority over all handshakes.

Optional Feature:
- Macro IMM_GEN_ZICSR_EN.
- Defined: CSRI gives zimm = instr[19:15], zero-extended; out_illegal=0.
- Undefined: CSRI is illegal (imm_ext=0, out_illegal=1). In AUTO_DECODE mode, opcode 1110011 with funct3[2]=1 is also flagged illegal.

Decomposition:
- imm_pkg holds imm_src_e (3-bit enum with the codes above), opcode localparams, and a pipeline state enum {EMPTY, ONE, FULL}.
- One combinational sub-module, imm_decode (parameter XLEN), takes instr and src and returns imm and illegal. It is instantiated once per input path, before the main/skid registers.

Test Plan:
- XLEN=32, imm_src=I, instr=0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm_ext=0xFFFFFFFF, out_illegal=0, out_tag=in_tag.
- imm_src=B, instr=0xFE000EE3 -> imm_ext=0xFFFFFFFC. imm_src=S, instr=0x0020A423 -> imm_ext=0x00000008.
- XLEN=64, AUTO_DECODE=1, instr=0x800002B7 (lui) -> imm_ext=0xFFFFFFFF80000000. XLEN=32, SHAMT, instr=0x02009093 -> out_illegal=1, imm_ext=0.
- Backpressure: send 3 back-to-back entries with out_ready=0 -> in_ready falls after 2 accepts. Raise out_ready -> entries emerge in order with no loss or duplication, outputs stable while stalled.
- flush in FULL state with in_valid=1 -> next cycle out_valid=0 and in_ready=1, nothing emitted. Assert rst_n=0 asynchronously mid-stream -> outputs zero immediately.
- imm_src=CSRI, instr=0x0002D073 -> with IMM_GEN_ZICSR_EN, imm_ext=0x00000005. Without it, out_illegal=1 and imm_ext=0.
